// File: rtl/key_bounce_gen_if.sv
// Request/response bundle for the contact-bounce generator: start/level in, bouncy line and status out.
// master drives the request side, slave is the generator itself.
interface key_bounce_gen_if;
    logic       start;
    logic       level;
    logic       outv;
    logic       busy;
    logic       done;
    logic [7:0] edge_cnt;

    modport master (
        output start,
        output level,
        input  outv,
        input  busy,
        input  done,
        input  edge_cnt
    );

    modport slave (
        input  start,
        input  level,
        output outv,
        output busy,
        output done,
        output edge_cnt
    );
endinterface

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing mechanical contact: toggles outv BOUNCE_EDGES times at LFSR-randomised gaps, then settles at the target level.
// Busy from the cycle after an accepted start until a one-cycle done; no backpressure, starts while busy are dropped.
module key_bounce_gen #(
    parameter int unsigned    BOUNCE_EDGES  = 6,
    parameter int unsigned    MIN_GAP       = 1,
    parameter logic [7:0]     GAP_MASK      = 8'h1F,
    parameter int unsigned    SETTLE_CYCLES = 20,
    parameter logic [15:0]    SEED          = 16'hACE1
) (
    input  logic              clk,
    input  logic              rstv,
    key_bounce_gen_if.slave   bus
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_BOUNCE = 2'd1;
    localparam logic [1:0]  S_SETTLE = 2'd2;

    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  EDGES8    = BOUNCE_EDGES[7:0];
    localparam logic [8:0]  MIN_GAP9  = {1'b0, MIN_GAP[7:0]};
    localparam logic [15:0] SETTLE16  = SETTLE_CYCLES[15:0];

    logic [1:0]  state_q,  state_d;
    logic [15:0] lfsr_q,   lfsr_d;
    logic        outv_q,   outv_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic        tgt_q,    tgt_d;
    logic [7:0]  bcnt_q,   bcnt_d;
    logic [8:0]  gap_q,    gap_d;
    logic [15:0] hold_q,   hold_d;

    logic [8:0]  gap_val;
    logic [7:0]  cnt_inc;
    logic        lfsr_fb;

    // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign gap_val = MIN_GAP9 + {1'b0, lfsr_q[7:0] & GAP_MASK};
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        outv_d  = outv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        bcnt_d  = bcnt_q;
        gap_d   = gap_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tgt_d  = bus.level;
                    cnt_d  = 8'd0;
                    busy_d = 1'b1;
                    if ((EDGES8 != 8'd0) || (bus.level != outv_q)) begin
                        gap_d   = gap_val;
                        bcnt_d  = 8'd0;
                        state_d = S_BOUNCE;
                    end else begin
                        hold_d  = SETTLE16;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_BOUNCE: begin
                // A gap of G loaded at edge e expires at edge e+G.
                if (gap_q <= 9'd1) begin
                    if (bcnt_q < EDGES8) begin
                        outv_d = ~outv_q;
                        cnt_d  = cnt_inc;
                        bcnt_d = bcnt_q + 8'd1;
                        gap_d  = gap_val;
                    end else begin
                        outv_d  = tgt_q;
                        if (tgt_q != outv_q) begin
                            cnt_d = cnt_inc;
                        end
                        hold_d  = SETTLE16;
                        state_d = S_SETTLE;
                    end
                end else begin
                    gap_d = gap_q - 9'd1;
                end
            end
            S_SETTLE: begin
                if (hold_q <= 16'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstv) begin
        if (rstv) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_INIT;
            outv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
            tgt_q   <= 1'b0;
            bcnt_q  <= 8'd0;
            gap_q   <= 9'd0;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            outv_q  <= outv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            bcnt_q  <= bcnt_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.outv     = outv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.edge_cnt = cnt_q;

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
Stimulus-side counterpart to the key debouncer. It takes a clean "press/release to level L" request and drives a single-bit line that chatters the way a mechanical contact does. The line toggles a programmable number of times at pseudo-random intervals, then settles at L and holds it.
Used on-chip for self-test of debounce paths and as a reusable bench driver for every key-input block in the design.

Parameters:
BOUNCE_EDGES, 6, number of spurious toggles before the final settle (0..255)
MIN_GAP, 1, minimum cycles between successive output events (1..255)
GAP_MASK, 8'h1F, mask applied to LFSR[7:0] and added to MIN_GAP (0..255)
SETTLE_CYCLES, 20, cycles outv is held at target before done (1..65535)
SEED, 16'hACE1, LFSR reset value; SEED==0 loads 16'h0001 instead

Ports:
clk  input  1  system clock, all logic on rising edge
rstv  input  1  asynchronous reset, active-high
start  input  1  request strobe, sampled only in IDLE
level  input  1  target settled level, captured with an accepted start
outv  output  1  bouncy contact emulation output
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when settle hold completes
edge_cnt  output  8  number of outv transitions in the current/last operation

Behaviour:
- Reset (async, rstv=1): outv=0, busy=0, done=0, edge_cnt=0, state=IDLE, LFSR=SEED (or 1 if SEED==0). All counters cleared. Reset mid-operation aborts immediately; no done pulse is issued.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clock whether busy or idle. Sequence is fully deterministic from reset.
- Gap value G = MIN_GAP + (LFSR[7:0] & GAP_MASK), 9-bit unsigned, no overflow. G is computed from the LFSR value present at the load edge.
- Gap counting: G is loaded at edge e; the scheduled event happens at edge e+G.
- States: IDLE, BOUNCE, SETTLE.
- IDLE:
  - done is low except for its single pulse cycle.
  - start=1 at edge t: capture target=level, clear edge_cnt, set busy=1.
  - If BOUNCE_EDGES>0 or target!=outv: load G, bounce count=0, go BOUNCE.
  - If BOUNCE_EDGES==0 and target==outv: go straight to SETTLE with hold count loaded.
- BOUNCE: on each gap expiry:
  - If bounce count < BOUNCE_EDGES: outv <= ~outv, edge_cnt++, bounce count++, reload G.
  - Otherwise: outv <= target (edge_cnt++ only if this changes outv), load hold count, go SETTLE.
  - Total transitions = BOUNCE_EDGES, plus 1 if the final write changes outv.
- SETTLE:
  - outv held constant.
  - If the final write happened at edge s, done=1 and busy=0 at edge s+SETTLE_CYCLES; state returns to IDLE.
  - For the direct IDLE->SETTLE path, s = t.
- done lasts exactly one cycle. A start in that same cycle is accepted, because the state is IDLE.
- start while busy: ignored, with no queuing. level changes while busy: ignored.
- edge_cnt saturates at 255 and holds its value after done until the next accepted start.
- outv changes only at a gap expiry or at the final write; it never glitches between cycles.

Test Plan:
1. MIN_GAP=1, GAP_MASK=0, BOUNCE_EDGES=6, SETTLE_CYCLES=20, outv=0, start with level=1 at edge t -> outv=1,0,1,0,1,0 at edges t+1..t+6; outv=1 at t+7; edge_cnt=7; done pulse at t+27; busy high t+1..t+26.
2. Same config, release with level=0 from outv=1 -> 7 transitions, final outv=0; feeding outv into the debouncer yields exactly one debounced change.
3. BOUNCE_EDGES=0, start with level equal to outv -> no transitions, edge_cnt=0, done at t+SETTLE_CYCLES.
4. BOUNCE_EDGES=5 (odd), GAP_MASK=0, level=1 from 0 -> 5 toggles leave outv=1; final write causes no change; edge_cnt=5.
5. Default GAP_MASK, two runs from reset with the same SEED -> identical edge timing; every gap is in [MIN_GAP, MIN_GAP+31].
6. rstv pulsed mid-BOUNCE, plus start asserted while busy -> outv/busy/done/edge_cnt return to 0 immediately with no done; the busy-time start is ignored and edge count is unaffected.
